// File: rtl/bs_data_feeder.sv
// Upstream data stage for the Black-Scholes controller: streams option records
// out of a 32-bit BRAM into per-module operand registers on request.
module bs_data_feeder #(
    parameter int unsigned BSMODS   = 1,
    parameter int unsigned DATASIZE = 192,
    parameter int unsigned WORDW    = 32,
    parameter int unsigned ADDRW    = 12,
    parameter int unsigned RECW     = 10
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       startSystem,
    input  logic [RECW-1:0]            num_records,
    input  logic [BSMODS-1:0]          SERVE_REG,
    input  logic [BSMODS-1:0]          BS_START,
    output logic                       mem_rd_en,
    output logic [ADDRW-1:0]           mem_addr,
    input  logic [WORDW-1:0]           mem_rdata,
    output logic [BSMODS*DATASIZE-1:0] bs_data,
    output logic [BSMODS-1:0]          hasUnusedData,
    output logic [BSMODS-1:0]          REG_READY,
    output logic                       OutOfData
);

    localparam int unsigned WORDS = DATASIZE / WORDW;
    localparam int unsigned CNTW  = $clog2(WORDS + 1);
    localparam int unsigned MODW  = (BSMODS > 1) ? $clog2(BSMODS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        FILL  = 2'd2,
        EMPTY = 2'd3
    } state_t;

    state_t              state;
    logic [RECW-1:0]     rec_cnt;
    logic [RECW-1:0]     rec_total;
    logic [ADDRW-1:0]    addr;
    logic [CNTW-1:0]     rd_cnt;
    logic [CNTW-1:0]     cap_idx;
    logic                cap_valid;
    logic [MODW-1:0]     rr_ptr;
    logic [MODW-1:0]     fill_mod;
    logic [DATASIZE-1:0] rec_buf;

    logic [BSMODS-1:0]   eligible_c;
    logic                grant_c;
    logic [MODW-1:0]     grant_mod_c;
    logic [MODW-1:0]     grant_ptr_c;
    logic [DATASIZE-1:0] rec_next_c;

    // Round-robin pick among modules asking for data with an empty register
    always_comb begin
        int unsigned idx;
        idx         = 0;
        eligible_c  = SERVE_REG & ~hasUnusedData;
        grant_c     = 1'b0;
        grant_mod_c = '0;
        grant_ptr_c = rr_ptr;
        for (int k = 0; k < BSMODS; k++) begin
            idx = (32'(rr_ptr) + 32'(k)) % BSMODS;
            if (!grant_c && eligible_c[MODW'(idx)]) begin
                grant_c     = 1'b1;
                grant_mod_c = MODW'(idx);
                grant_ptr_c = MODW'((idx + 1) % BSMODS);
            end
        end
    end

    // Record being assembled, with the word arriving this cycle merged in
    always_comb begin
        rec_next_c = rec_buf;
        for (int w = 0; w < WORDS; w++) begin
            if (cap_idx == CNTW'(w)) begin
                rec_next_c[w*WORDW +: WORDW] = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rec_cnt       <= '0;
            rec_total     <= '0;
            addr          <= '0;
            rd_cnt        <= '0;
            cap_idx       <= '0;
            cap_valid     <= 1'b0;
            rr_ptr        <= '0;
            fill_mod      <= '0;
            rec_buf       <= '0;
            mem_rd_en     <= 1'b0;
            mem_addr      <= '0;
            bs_data       <= '0;
            hasUnusedData <= '0;
            REG_READY     <= '1;
            OutOfData     <= 1'b0;
        end else begin
            // A started module has taken its operands; its register is free again
            hasUnusedData <= hasUnusedData & ~BS_START;
            cap_valid     <= mem_rd_en;

            case (state)
                IDLE: begin
                    if (startSystem) begin
                        rec_total <= num_records;
                        rec_cnt   <= '0;
                        addr      <= '0;
                        state     <= ARB;
                    end
                end

                ARB: begin
                    if (rec_cnt == rec_total) begin
                        OutOfData <= 1'b1;
                        state     <= EMPTY;
                    end else if (grant_c) begin
                        fill_mod               <= grant_mod_c;
                        rr_ptr                 <= grant_ptr_c;
                        REG_READY[grant_mod_c] <= 1'b0;
                        mem_rd_en              <= 1'b1;
                        mem_addr               <= addr;
                        addr                   <= addr + 1'b1;
                        rd_cnt                 <= CNTW'(1);
                        cap_idx                <= '0;
                        state                  <= FILL;
                    end
                end

                FILL: begin
                    if (rd_cnt < CNTW'(WORDS)) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr;
                        addr      <= addr + 1'b1;
                        rd_cnt    <= rd_cnt + 1'b1;
                    end else begin
                        mem_rd_en <= 1'b0;
                    end

                    if (cap_valid) begin
                        rec_buf <= rec_next_c;
                        cap_idx <= cap_idx + 1'b1;
                        // Last word in: publish the whole record at once
                        if (cap_idx == CNTW'(WORDS - 1)) begin
                            for (int i = 0; i < BSMODS; i++) begin
                                if (MODW'(i) == fill_mod) begin
                                    bs_data[i*DATASIZE +: DATASIZE] <= rec_next_c;
                                    hasUnusedData[i]                <= 1'b1;
                                    REG_READY[i]                    <= 1'b1;
                                end
                            end
                            rec_cnt <= rec_cnt + 1'b1;
                            state   <= ARB;
                        end
                    end
                end

                EMPTY: begin
                    OutOfData <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_data_feeder.sv
// Randomized scoreboard bench for bs_data_feeder with two operand registers.
module tb_bs_data_feeder;

    localparam int unsigned BSMODS   = 2;
    localparam int unsigned DATASIZE = 192;
    localparam int unsigned WORDW    = 32;
    localparam int unsigned ADDRW    = 12;
    localparam int unsigned RECW     = 10;
    localparam int unsigned WORDS    = DATASIZE / WORDW;
    localparam int unsigned DW       = DATASIZE;

    logic                       clock = 1'b0;
    logic                       reset_n = 1'b1;
    logic                       startSystem = 1'b0;
    logic [RECW-1:0]            num_records = '0;
    logic [BSMODS-1:0]          SERVE_REG = '0;
    logic [BSMODS-1:0]          BS_START = '0;
    logic                       mem_rd_en;
    logic [ADDRW-1:0]           mem_addr;
    logic [WORDW-1:0]           mem_rdata = '0;
    logic [BSMODS*DATASIZE-1:0] bs_data;
    logic [BSMODS-1:0]          hasUnusedData;
    logic [BSMODS-1:0]          REG_READY;
    logic                       OutOfData;

    bs_data_feeder #(
        .BSMODS(BSMODS), .DATASIZE(DATASIZE), .WORDW(WORDW), .ADDRW(ADDRW), .RECW(RECW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .startSystem(startSystem),
        .num_records(num_records), .SERVE_REG(SERVE_REG), .BS_START(BS_START),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .bs_data(bs_data), .hasUnusedData(hasUnusedData), .REG_READY(REG_READY),
        .OutOfData(OutOfData)
    );

    always #5 clock = ~clock;

    logic [WORDW-1:0] mem [0:(1<<ADDRW)-1];

    // 1-cycle-latency BRAM
    always @(posedge clock) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        int               mod;
        logic [DW-1:0]    data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   reads_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record k is WORDS consecutive BRAM words, word 0 in the low bits
    function automatic logic [DW-1:0] rec(input int k);
        logic [DW-1:0] r;
        r = '0;
        for (int w = 0; w < WORDS; w++) r[w*WORDW +: WORDW] = mem[k*WORDS + w];
        return r;
    endfunction

    task automatic push(input int m, input int k);
        exp_t e;
        e.mod  = m;
        e.data = rec(k);
        exp_q.push_back(e);
    endtask

    // Monitor: address sequence, fill latency and delivered record contents
    initial begin
        int            cyc;
        int            t0;
        int            burst;
        int            exp_addr;
        logic          prev_rd;
        logic [BSMODS-1:0] prev_hud;
        exp_t          e;
        cyc = 0; t0 = 0; burst = 0; exp_addr = 0; prev_rd = 1'b0; prev_hud = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                exp_q.delete();
                exp_addr = 0;
                prev_rd  = 1'b0;
                prev_hud = '0;
            end else begin
                if (startSystem) exp_addr = 0;
                if (mem_rd_en) begin
                    if (!prev_rd) begin
                        t0    = cyc;
                        burst = 0;
                    end
                    chk("read_addr", DW'(mem_addr), DW'(exp_addr % (1 << ADDRW)));
                    chk("reg_ready_low_in_fill", DW'(REG_READY != {BSMODS{1'b1}}), DW'(1));
                    exp_addr++;
                    burst++;
                    reads_total++;
                end
                for (int i = 0; i < BSMODS; i++) begin
                    if (hasUnusedData[i] && !prev_hud[i]) begin
                        chk("fill_expected", DW'(exp_q.size() != 0), DW'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("fill_module", DW'(i), DW'(e.mod));
                            chk("fill_data", bs_data[i*DATASIZE +: DATASIZE], e.data);
                            chk("fill_latency", DW'(cyc - t0), DW'(WORDS + 1));
                            chk("fill_burst", DW'(burst), DW'(WORDS));
                            chk("reg_ready_after_fill", DW'(REG_READY[i]), DW'(1));
                        end
                    end
                end
                prev_hud = hasUnusedData;
                prev_rd  = mem_rd_en;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        SERVE_REG   = '0;
        BS_START    = '0;
        startSystem = 1'b0;
        reset_n     = 1'b0;
        tick(3);
        reset_n     = 1'b1;
        tick(1);
    endtask

    task automatic start();
        startSystem = 1'b1;
        tick(1);
        startSystem = 1'b0;
    endtask

    task automatic pulse_bs(input logic [BSMODS-1:0] m);
        BS_START = m;
        tick(1);
        BS_START = '0;
    endtask

    task automatic wait_hud(input logic [BSMODS-1:0] m);
        int n;
        n = 0;
        while ((hasUnusedData & m) != m && n < 500) begin
            tick(1);
            n++;
        end
        chk("hud_wait", DW'((hasUnusedData & m) == m), DW'(1));
    endtask

    task automatic wait_ood();
        int n;
        n = 0;
        while (!OutOfData && n < 500) begin
            tick(1);
            n++;
        end
        chk("ood_wait", DW'(OutOfData), DW'(1));
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int nrec;
        int n;
        int k;
        logic [DW-1:0] snap;

        for (int i = 0; i < (1 << ADDRW); i++) mem[i] = '0;
        #2;
        do_reset();

        // Reset state
        chk("rst_rd_en", DW'(mem_rd_en), DW'(0));
        chk("rst_addr", DW'(mem_addr), DW'(0));
        chk("rst_hud", DW'(hasUnusedData), DW'(0));
        chk("rst_reg_ready", DW'(REG_READY), DW'({BSMODS{1'b1}}));
        chk("rst_ood", DW'(OutOfData), DW'(0));
        for (int i = 0; i < BSMODS; i++) chk("rst_bs_data", bs_data[i*DATASIZE +: DATASIZE], DW'(0));

        // Single fill with a fixed pattern
        for (int w = 0; w < WORDS; w++) mem[w] = WORDW'(32'h11 * (w + 1));
        num_records = RECW'(1);
        base = reads_total;
        push(0, 0);
        SERVE_REG = 2'b01;
        start();
        wait_hud(2'b01);
        chk("single_pattern", bs_data[0 +: DATASIZE],
            {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11});
        snap = bs_data[0 +: DATASIZE];
        pulse_bs(2'b01);
        chk("single_bs_clears", DW'(hasUnusedData), DW'(0));
        chk("single_bs_keeps_data", bs_data[0 +: DATASIZE], snap);
        tick(10);
        chk("single_ood", DW'(OutOfData), DW'(1));
        chk("single_reads", DW'(reads_total - base), DW'(WORDS));
        chk("single_drained", DW'(exp_q.size()), DW'(0));

        // Stream of random records to module 0, with an overwrite-guard hold
        do_reset();
        randomize_mem();
        nrec = $urandom_range(3, 5);
        num_records = RECW'(nrec);
        base = reads_total;
        for (int r = 0; r < nrec; r++) push(0, r);
        SERVE_REG = 2'b01;
        start();
        for (int r = 0; r < nrec; r++) begin
            wait_hud(2'b01);
            chk("stream_ood_low_at_fill", DW'(OutOfData), DW'(0));
            snap = bs_data[0 +: DATASIZE];
            if (r == 0) begin
                n = reads_total;
                tick(15);
                chk("guard_no_reads", DW'(reads_total - n), DW'(0));
                chk("guard_slice", bs_data[0 +: DATASIZE], snap);
            end
            tick($urandom_range(1, 5));
            pulse_bs(2'b01);
            chk("stream_bs_clears", DW'(hasUnusedData[0]), DW'(0));
            chk("stream_bs_keeps_data", bs_data[0 +: DATASIZE], snap);
        end
        wait_ood();
        chk("stream_reads", DW'(reads_total - base), DW'(nrec * WORDS));
        chk("stream_drained", DW'(exp_q.size()), DW'(0));

        // Round-robin between two modules
        do_reset();
        randomize_mem();
        num_records = RECW'(4);
        base = reads_total;
        push(0, 0); push(1, 1); push(0, 2); push(1, 3);
        SERVE_REG = 2'b11;
        start();
        wait_hud(2'b11);
        tick($urandom_range(1, 6));
        chk("rr_ood_low", DW'(OutOfData), DW'(0));
        pulse_bs(2'b11);
        wait_hud(2'b11);
        wait_ood();
        chk("rr_reads", DW'(reads_total - base), DW'(4 * WORDS));
        chk("rr_drained", DW'(exp_q.size()), DW'(0));

        // Zero records
        do_reset();
        num_records = '0;
        base = reads_total;
        SERVE_REG = 2'b11;
        start();
        chk("zero_ood_cycle1", DW'(OutOfData), DW'(0));
        tick(1);
        chk("zero_ood_cycle2", DW'(OutOfData), DW'(1));
        startSystem = 1'b1;
        tick(10);
        startSystem = 1'b0;
        chk("zero_no_reads", DW'(reads_total - base), DW'(0));
        chk("zero_ood_sticky", DW'(OutOfData), DW'(1));

        // Reset asserted on the third read of a fill
        do_reset();
        randomize_mem();
        num_records = RECW'(2);
        push(0, 0);
        SERVE_REG = 2'b01;
        start();
        n = 0;
        k = 0;
        while (n < 3 && k < 100) begin
            if (mem_rd_en) n++;
            if (n < 3) tick(1);
            k++;
        end
        chk("midfill_reached_read3", DW'(n), DW'(3));
        reset_n = 1'b0;
        #1;
        chk("midfill_rd_en", DW'(mem_rd_en), DW'(0));
        chk("midfill_hud", DW'(hasUnusedData), DW'(0));
        chk("midfill_reg_ready", DW'(REG_READY), DW'({BSMODS{1'b1}}));
        chk("midfill_ood", DW'(OutOfData), DW'(0));
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("midfill_idle_no_reads", DW'(mem_rd_en), DW'(0));
        num_records = RECW'(1);
        base = reads_total;
        push(0, 0);
        start();
        wait_hud(2'b01);
        wait_ood();
        chk("midfill_restart_reads", DW'(reads_total - base), DW'(WORDS));
        chk("midfill_drained", DW'(exp_q.size()), DW'(0));

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
